blink_rtk_sched_64_128: RTL and testbench
=========================================

Name: blink_rtk_sched_64_128

Overview:
Sequential round-tweakey scheduler for the Blink 64/128 datapath. It latches the 7-word master key and the 128-bit tweak, then streams the 14 per-round tweakeys over a valid/ready interface. The stream runs in forward order (round 0..13) for encryption or reverse order (round 13..0) for decryption. It sits beside the iterative round core and feeds it one subkey per round.

Parameters:
ROUND, 14, number of rounds; must be even
N, 64, block and subkey width in bits
TWEAK_LEN, 128, tweak width; must equal 2*N

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  request a new schedule; sampled only in IDLE
dec  input  1  1 = reverse (decryption) order, 0 = forward order; latched with start
K0  input  N*(ROUND/2)  master key; word i = K0[N*i +: N], i = 0..ROUND/2-1
T  input  TWEAK_LEN  tweak; T_lo = T[N-1:0], T_hi = T[2N-1:N]
busy  output  1  high from the cycle after start acceptance until return to IDLE
rtk_valid  output  1  subkey on rtk is valid
rtk_ready  input  1  consumer accepts subkey
rtk  output  N  round tweakey
rtk_idx  output  4  round index of the current rtk
rtk_last  output  1  current beat is the final beat of the stream
done  output  1  one-cycle pulse after the final beat transfers

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, beat counter=0, key/tweak/dec registers=0. Outputs busy, rtk_valid, rtk_last and done are 0; rtk=0 and rtk_idx=0. A reset mid-stream aborts the stream with no done pulse.
- Round tweakey definition: RTK[r] = K0 word (r>>1) XOR (r odd ? T_hi : T_lo), for r = 0..ROUND-1.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1, latch K0, T and dec, clear the counter, and go to RUN. Otherwise stay in IDLE.
- RUN:
  - busy=1 and rtk_valid=1.
  - rtk_idx = dec ? ROUND-1-cnt : cnt.
  - rtk = RTK[rtk_idx], computed from the latched registers only.
  - rtk_last = (cnt == ROUND-1).
- Handshake:
  - A beat transfers on a rising edge where rtk_valid && rtk_ready. The counter increments on each transfer.
  - On a transfer with rtk_last=1, go to DONE.
  - While rtk_ready=0, rtk, rtk_idx and rtk_last hold stable. rtk_valid never drops before the transfer.
- DONE: done=1 and busy=1 for exactly one cycle, rtk_valid=0, then unconditionally go to IDLE.
- Invalid-output gating: when rtk_valid=0, rtk, rtk_idx and rtk_last are driven to 0.
- start while in RUN or DONE is ignored; it does not restart or corrupt the stream.
- start in the IDLE cycle that follows DONE is accepted normally. Minimum spacing between two schedules is ROUND+2 cycles.
- Changes on K0, T or dec after acceptance have no effect on the current stream.
- Latency:
  - start accepted at edge 0; first beat valid in the cycle after edge 0.
  - With rtk_ready held at 1, the final beat transfers at edge ROUND and done is high in the following cycle.
- The counter is ceil(log2(ROUND)) bits wide. No wrap-around is reachable, because the DONE transition occurs at ROUND-1.

Decomposition:
- Shared package blink_pkg holds:
  - constants BLINK_N=64, BLINK_ROUND=14, BLINK_TWEAK_LEN=128;
  - the state enumeration {IDLE, RUN, DONE};
  - the RTK-index helper function (forward/reverse mapping).
- One natural sub-module, blink_rtk_mux: purely combinational. It selects the key word and tweak half and XORs them, given the latched key, latched tweak and round index. The FSM and handshake remain in the top block.

Test Plan:
- Common stimulus for all scenarios: K0 word i = i (64-bit), T_lo=64'hA5A5A5A5A5A5A5A5, T_hi=64'h5A5A5A5A5A5A5A5A.
- Forward order: dec=0, start pulse, rtk_ready=1 -> 14 consecutive beats. Beat 0 is idx 0, rtk=64'hA5A5A5A5A5A5A5A5. Beat 13 is idx 13, rtk=64'h5A5A5A5A5A5A5A5C with rtk_last=1. done is high exactly one cycle after beat 13.
- Reverse order: same stimulus with dec=1 -> first beat idx 13, rtk=64'h5A5A5A5A5A5A5A5C. Last beat idx 0, rtk=64'hA5A5A5A5A5A5A5A5. Total of 14 beats, then one done pulse.
- Backpressure: rtk_ready toggled pseudo-randomly, held low for 5 cycles at beat 6 -> rtk/rtk_idx stable while stalled. Exactly 14 transfers occur, no beat duplicated or skipped.
- Ignored start and input change: start=1 and K0/T overwritten with all-ones during RUN -> stream values unchanged from the forward-order sequence, and only one done pulse.
- Mid-stream reset: assert rst=0 asynchronously after beat 4 -> rtk_valid, busy and done drop to 0 immediately with no done pulse. After release, a new start with dec=0 restarts at idx 0.
- Back-to-back schedules: start held at 1 continuously -> the second schedule begins in the IDLE cycle after DONE. Spacing between first beats is exactly 16 cycles with ready=1.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared definitions for the Blink 64/128 round-tweakey scheduler.
//   BLINK_N         : block / subkey width
//   BLINK_ROUND     : number of rounds (even)
//   BLINK_TWEAK_LEN : tweak width (2*BLINK_N)
//   state_e         : scheduler FSM states
//   rtk_index()     : maps beat counter to round index (forward or reverse)
package blink_pkg;

  localparam int unsigned BLINK_N         = 64;
  localparam int unsigned BLINK_ROUND     = 14;
  localparam int unsigned BLINK_TWEAK_LEN = 128;
  localparam int unsigned BLINK_KEY_LEN   = BLINK_N * (BLINK_ROUND / 2);
  localparam int unsigned CNT_W           = $clog2(BLINK_ROUND);
  localparam int unsigned IDX_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Decryption walks the rounds backwards.
  function automatic logic [IDX_W-1:0] rtk_index(input logic rev, input logic [CNT_W-1:0] cnt);
    logic [IDX_W-1:0] w_last;
    w_last = IDX_W'(BLINK_ROUND - 1);
    return rev ? (w_last - IDX_W'(cnt)) : IDX_W'(cnt);
  endfunction

endpackage

// File: rtl/blink_rtk_sched_64_128_if.sv
// Round-tweakey stream interface (valid/ready).
//   rtk_valid : subkey valid (master -> slave)
//   rtk_ready : subkey accepted (slave -> master)
//   rtk       : round tweakey
//   rtk_idx   : round index of rtk
//   rtk_last  : final beat of the stream
interface blink_rtk_sched_64_128_if;
  import blink_pkg::*;

  logic               rtk_valid;
  logic               rtk_ready;
  logic [BLINK_N-1:0] rtk;
  logic [IDX_W-1:0]   rtk_idx;
  logic               rtk_last;

  modport master (
    output rtk_valid,
    output rtk,
    output rtk_idx,
    output rtk_last,
    input  rtk_ready
  );

  modport slave (
    input  rtk_valid,
    input  rtk,
    input  rtk_idx,
    input  rtk_last,
    output rtk_ready
  );

endinterface

// File: rtl/blink_rtk_mux.sv
// Combinational round-tweakey former: RTK[r] = key word (r>>1) ^ (r odd ? T_hi : T_lo).
//   i_key   : latched master key, word i at [N*i +: N]
//   i_tweak : latched tweak, {T_hi, T_lo}
//   i_idx   : round index
//   o_rtk   : round tweakey
module blink_rtk_mux
  import blink_pkg::*;
(
  input  logic [BLINK_KEY_LEN-1:0]   i_key,
  input  logic [BLINK_TWEAK_LEN-1:0] i_tweak,
  input  logic [IDX_W-1:0]           i_idx,
  output logic [BLINK_N-1:0]         o_rtk
);

  logic [IDX_W-2:0]   w_word_sel;
  logic [BLINK_N-1:0] w_word;
  logic [BLINK_N-1:0] w_half;

  always_comb begin
    w_word_sel = i_idx[IDX_W-1:1];
    w_word     = i_key[w_word_sel*BLINK_N +: BLINK_N];
    w_half     = i_idx[0] ? i_tweak[2*BLINK_N-1:BLINK_N] : i_tweak[BLINK_N-1:0];
    o_rtk      = w_word ^ w_half;
  end

endmodule

// File: rtl/blink_rtk_sched_64_128.sv
// Sequential round-tweakey scheduler for Blink 64/128. Latches key, tweak and direction
// on start, then streams ROUND subkeys over a valid/ready interface.
//   clk, rst : clock, asynchronous active-low reset
//   start    : request a schedule (sampled in IDLE only)
//   dec      : 1 = reverse round order
//   K0, T    : master key words, tweak
//   busy     : schedule in progress (RUN or DONE)
//   done     : one-cycle pulse after the final beat transfers
//   rtk_if   : subkey stream (master side)
module blink_rtk_sched_64_128
  import blink_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       dec,
  input  logic [BLINK_KEY_LEN-1:0]   K0,
  input  logic [BLINK_TWEAK_LEN-1:0] T,
  output logic                       busy,
  output logic                       done,
  blink_rtk_sched_64_128_if.master   rtk_if
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLINK_ROUND - 1);

  state_e                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [BLINK_KEY_LEN-1:0]   r_key;
  logic [BLINK_TWEAK_LEN-1:0] r_tweak;
  logic                       r_dec;

  logic                       w_valid;
  logic [IDX_W-1:0]           w_idx;
  logic [BLINK_N-1:0]         w_rtk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_key   <= '0;
      r_tweak <= '0;
      r_dec   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_key   <= K0;
            r_tweak <= T;
            r_dec   <= dec;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (rtk_if.rtk_ready) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_CNT) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_idx = rtk_index(r_dec, r_cnt);

  blink_rtk_mux u_mux (
    .i_key   (r_key),
    .i_tweak (r_tweak),
    .i_idx   (w_idx),
    .o_rtk   (w_rtk)
  );

  // All outputs derive from registered state only; data lanes are zeroed when not valid.
  always_comb begin
    w_valid          = (r_state == RUN);
    busy             = (r_state != IDLE);
    done             = (r_state == DONE);
    rtk_if.rtk_valid = w_valid;
    rtk_if.rtk       = w_valid ? w_rtk : '0;
    rtk_if.rtk_idx   = w_valid ? w_idx : '0;
    rtk_if.rtk_last  = w_valid && (r_cnt == LAST_CNT);
  end

endmodule

// File: tb/tb_blink_rtk_sched_64_128.sv
module tb_blink_rtk_sched_64_128;
  import blink_pkg::*;

  localparam logic [63:0] TLO = 64'hA5A5A5A5A5A5A5A5;
  localparam logic [63:0] THI = 64'h5A5A5A5A5A5A5A5A;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       start = 1'b0;
  logic                       dec = 1'b0;
  logic [BLINK_KEY_LEN-1:0]   k0;
  logic [BLINK_TWEAK_LEN-1:0] t;
  logic                       busy;
  logic                       done;

  blink_rtk_sched_64_128_if u_if ();

  blink_rtk_sched_64_128 dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .dec    (dec),
    .K0     (k0),
    .T      (t),
    .busy   (busy),
    .done   (done),
    .rtk_if (u_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of the beats still owed to the consumer.
  typedef struct {
    logic [3:0]  idx;
    logic [63:0] rtk;
    logic        last;
  } beat_t;

  beat_t m_q[$];
  bit    m_done = 1'b0;

  function automatic logic [63:0] ref_rtk(input logic [BLINK_KEY_LEN-1:0] key,
                                          input logic [127:0] tw, input int r);
    return key[64*(r/2) +: 64] ^ (((r % 2) == 1) ? tw[127:64] : tw[63:0]);
  endfunction

  always @(posedge clk or negedge rst) begin
    bit    busy_pre;
    bit    nd;
    beat_t b;
    if (!rst) begin
      m_q.delete();
      m_done = 1'b0;
    end else begin
      busy_pre = (m_q.size() != 0) || m_done;
      nd = 1'b0;
      if (m_q.size() != 0 && u_if.rtk_ready) begin
        b  = m_q.pop_front();
        nd = b.last;
      end
      if (!busy_pre && start) begin
        for (int i = 0; i < 14; i++) begin
          int r;
          r      = dec ? 13 - i : i;
          b.idx  = 4'(r);
          b.rtk  = ref_rtk(k0, t, r);
          b.last = (i == 13);
          m_q.push_back(b);
        end
      end
      m_done = nd;
    end
  end

  int cyc = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int rise_cyc[$];
  bit prev_v = 1'b0;

  always @(posedge clk) cyc++;

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    bit    ev;
    beat_t h;
    ev = (m_q.size() != 0);
    h.idx = '0; h.rtk = '0; h.last = 1'b0;
    if (ev) h = m_q[0];
    chk("valid", u_if.rtk_valid, ev);
    chk("rtk", u_if.rtk, ev ? h.rtk : 64'd0);
    chk("idx", u_if.rtk_idx, ev ? h.idx : 4'd0);
    chk("last", u_if.rtk_last, ev ? h.last : 1'b0);
    chk("busy", busy, ev || m_done);
    chk("done", done, m_done);
    if (u_if.rtk_valid && u_if.rtk_ready) xfer_cnt++;
    if (u_if.rtk_valid && !prev_v) rise_cyc.push_back(cyc);
    prev_v = u_if.rtk_valid;
    if (done) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (!done && k < 200) begin
      tick;
      k++;
    end
    chk(nm, done, 1'b1);
  endtask

  task automatic run_ordered(input bit d, input string nm);
    int k;
    u_if.rtk_ready = 1'b1;
    dec = d;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk({nm, "_first_idx"}, u_if.rtk_idx, d ? 4'd13 : 4'd0);
    chk({nm, "_first_rtk"}, u_if.rtk, d ? (THI ^ 64'd6) : TLO);
    k = 0;
    while (!done && k < 40) begin
      tick;
      k++;
      if (k == 13) begin
        chk({nm, "_last_idx"}, u_if.rtk_idx, d ? 4'd0 : 4'd13);
        chk({nm, "_last_rtk"}, u_if.rtk, d ? TLO : 64'h5A5A5A5A5A5A5A5C);
        chk({nm, "_last_flag"}, u_if.rtk_last, 1'b1);
      end
    end
    chk({nm, "_done_latency"}, k, 14);
    tick;
    chk({nm, "_idle_after"}, busy, 1'b0);
  endtask

  initial begin
    int          x0;
    int          d0;
    int          r0;
    int          k;
    bit          stalled;
    logic [63:0] snap_rtk;
    logic [3:0]  snap_idx;

    for (int i = 0; i < 7; i++) k0[64*i +: 64] = 64'(i);
    t = {THI, TLO};
    u_if.rtk_ready = 1'b0;

    // Reset state
    repeat (3) tick;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", u_if.rtk_valid, 1'b0);
    chk("rst_rtk", u_if.rtk, 64'd0);
    chk("rst_idx", u_if.rtk_idx, 4'd0);
    chk("rst_done", done, 1'b0);
    rst = 1'b1;
    tick;

    // Pin the model's view of the stimulus
    dec = 1'b0;
    start = 1'b1;
    u_if.rtk_ready = 1'b0;
    tick;
    start = 1'b0;
    chk("model_len", m_q.size(), 14);
    chk("model_first", m_q[0].rtk, TLO);
    chk("model_last", m_q[13].rtk, 64'h5A5A5A5A5A5A5A5C);
    u_if.rtk_ready = 1'b1;
    wait_done("pin_done");
    tick;

    run_ordered(1'b0, "fwd");
    run_ordered(1'b1, "rev");

    // Backpressure with a forced 5-cycle stall at beat 6
    x0 = xfer_cnt;
    d0 = done_cnt;
    dec = 1'b0;
    u_if.rtk_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    stalled = 1'b0;
    k = 0;
    while (!done && k < 300) begin
      if (!stalled && u_if.rtk_valid && u_if.rtk_idx == 4'd6) begin
        stalled = 1'b1;
        u_if.rtk_ready = 1'b0;
        snap_rtk = u_if.rtk;
        snap_idx = u_if.rtk_idx;
        repeat (5) tick;
        chk("stall_rtk", u_if.rtk, snap_rtk);
        chk("stall_idx", u_if.rtk_idx, snap_idx);
        chk("stall_valid", u_if.rtk_valid, 1'b1);
      end
      u_if.rtk_ready = 1'($urandom_range(0, 1));
      tick;
      k++;
    end
    chk("bp_done_seen", done, 1'b1);
    chk("bp_stall_seen", stalled, 1'b1);
    tick;
    chk("bp_xfers", xfer_cnt - x0, 14);
    chk("bp_done_pulses", done_cnt - d0, 1);

    // Start and input changes during RUN are ignored
    d0 = done_cnt;
    u_if.rtk_ready = 1'b1;
    dec = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    start = 1'b1;
    k0 = '1;
    t = '1;
    dec = 1'b1;
    repeat (5) tick;
    chk("ign_idx", u_if.rtk_idx, 4'd8);
    chk("ign_rtk", u_if.rtk, TLO ^ 64'd4);
    start = 1'b0;
    wait_done("ign_done");
    for (int i = 0; i < 7; i++) k0[64*i +: 64] = 64'(i);
    t = {THI, TLO};
    dec = 1'b0;
    repeat (4) tick;
    chk("ign_done_pulses", done_cnt - d0, 1);

    // Asynchronous reset mid-stream
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (5) tick;
    chk("mrst_pre_idx", u_if.rtk_idx, 4'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_valid", u_if.rtk_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    d0 = done_cnt;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    chk("mrst_no_done", done_cnt - d0, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("mrst_restart_idx", u_if.rtk_idx, 4'd0);
    chk("mrst_restart_rtk", u_if.rtk, TLO);
    wait_done("mrst_done_after");
    tick;

    // Back-to-back schedules with start held high
    r0 = rise_cyc.size();
    start = 1'b1;
    repeat (40) tick;
    start = 1'b0;
    k = 0;
    while (busy && k < 100) begin
      tick;
      k++;
    end
    chk("b2b_idle", busy, 1'b0);
    chk("b2b_streams", rise_cyc.size() - r0, 3);
    if (rise_cyc.size() - r0 >= 2) begin
      chk("b2b_spacing", rise_cyc[r0+1] - rise_cyc[r0], 16);
    end else begin
      chk("b2b_spacing_missing", rise_cyc.size() - r0, 2);
    end
    repeat (2) tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
